// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_addsub.sv
// Ripple-carry adder/subtractor built from full-adder cells.
module div_addsub_step
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o
);

    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b_i ^ {N{sub_i}};
    assign c[0] = sub_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider: one add/sub step per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e state_q, state_d;

    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dbz_q, dbz_d;

    logic             dvs_zero;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_negv, dvs_negv;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   step_a, step_sum;
    logic             step_sub;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] q_negv, r_negv;

    assign dvs_zero = (divisor == '0);
    assign dvd_neg  = signed_op & dividend[WIDTH-1];
    assign dvs_neg  = signed_op & divisor[WIDTH-1];
    assign dvd_abs  = dvd_neg ? dvd_negv : dividend;
    assign dvs_abs  = dvs_neg ? dvs_negv : divisor;

    // FIX reuses the step unit as a plain add to restore a negative PR
    assign step_a   = (state_q == FIX) ? pr_q : {pr_q[WIDTH-1:0], qw_q[WIDTH-1]};
    assign step_sub = (state_q == FIX) ? 1'b0 : ~pr_q[WIDTH];
    assign rem_fix  = pr_q[WIDTH] ? step_sum[WIDTH-1:0] : pr_q[WIDTH-1:0];

    div_addsub_step #(.N(WIDTH + 1)) u_step (
        .a_i   (step_a),
        .b_i   ({1'b0, d_q}),
        .sub_i (step_sub),
        .sum_o (step_sum)
    );

    div_addsub_step #(.N(WIDTH)) u_neg_dvd (
        .a_i   ('0),
        .b_i   (dividend),
        .sub_i (1'b1),
        .sum_o (dvd_negv)
    );

    div_addsub_step #(.N(WIDTH)) u_neg_dvs (
        .a_i   ('0),
        .b_i   (divisor),
        .sub_i (1'b1),
        .sum_o (dvs_negv)
    );

    div_addsub_step #(.N(WIDTH)) u_neg_q (
        .a_i   ('0),
        .b_i   (qw_q),
        .sub_i (1'b1),
        .sum_o (q_negv)
    );

    div_addsub_step #(.N(WIDTH)) u_neg_r (
        .a_i   ('0),
        .b_i   (rem_fix),
        .sub_i (1'b1),
        .sum_o (r_negv)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = dvs_zero ? DONE : RUN;
            RUN:  if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN) || (state_q == FIX);
        done        = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

    always_comb begin
        pr_d   = pr_q;
        qw_d   = qw_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        negq_d = negq_q;
        negr_d = negr_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pr_d   = '0;
                    qw_d   = dvd_abs;
                    d_d    = dvs_abs;
                    cnt_d  = CW'(WIDTH - 1);
                    negq_d = dvd_neg ^ dvs_neg;
                    negr_d = dvd_neg;
                    dbz_d  = dvs_zero;
                    if (dvs_zero) begin
                        quot_d = WIDTH'(DIV_ZERO_QUOT);
                        rem_d  = dividend;
                    end
                end
            end
            RUN: begin
                pr_d  = step_sum;
                qw_d  = {qw_q[WIDTH-2:0], ~step_sum[WIDTH]};
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                quot_d = negq_q ? q_negv : qw_q;
                rem_d  = negr_q ? r_negv : rem_fix;
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pr_q   <= '0;
            qw_q   <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            pr_q   <= pr_d;
            qw_q   <= qw_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, scoreboard, corner sequences.
module tb_seq_divider;

    typedef struct {
        bit          sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dbz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[15];

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse retires the oldest accepted operation
    always @(negedge clk) begin
        if (!clr && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("busy_with_done", 32'(busy), 32'(0));
            end
        end
    end

    task automatic start_div(input bit sop, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er, input bit edbz);
        exp_t e;
        e.q = eq;
        e.r = er;
        e.dbz = edbz;
        sb.push_back(e);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycle 0 is the cycle start is presented; returns during the done cycle
    task automatic wait_done(input int exp_lat, input bit edbz, input int inj_cyc);
        int cyc;
        int nbusy;
        bit seen;
        cyc = 1;
        nbusy = 0;
        seen = 0;
        check("dbz_after_accept", 32'(div_by_zero), 32'(edbz));
        while (!seen && cyc < 60) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) nbusy++;
                if (cyc == inj_cyc) begin
                    start    = 1'b1;
                    dividend = 32'd9;
                    divisor  = 32'd3;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                cyc++;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        check("latency", 32'(cyc), 32'(exp_lat));
        check("busy_cycles", 32'(nbusy), 32'(exp_lat - 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clr       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
        vecs[1]  = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0};
        vecs[2]  = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0};
        vecs[3]  = '{0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1};
        vecs[4]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
        vecs[5]  = '{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          0};
        vecs[6]  = '{0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          0};
        vecs[7]  = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   0};
        vecs[8]  = '{1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1};
        vecs[9]  = '{0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   0};
        vecs[10] = '{0, 32'd3,          32'd10,         32'd0,          32'd3,          0};
        vecs[11] = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          0};
        vecs[12] = '{1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          0};
        vecs[13] = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0};
        vecs[14] = '{1, 32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   0};

        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Each row issues back-to-back on the cycle after the previous done
        for (int i = 0; i < 15; i++) begin
            start_div(vecs[i].sop, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
            wait_done(vecs[i].dbz ? 1 : 34, vecs[i].dbz, 0);
            @(posedge clk);
            #1;
            check("idle_after_done", 32'({busy, done}), 32'(0));
        end

        start_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        wait_done(34, 0, 10);
        @(posedge clk);
        #1;
        start_div(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        wait_done(34, 0, 0);
        @(posedge clk);
        #1;

        start_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        for (int c = 1; c < 15; c++) begin
            @(posedge clk);
            #1;
        end
        #3;
        clr = 1'b1;
        #1;
        sb.delete();
        check("clr_busy", 32'(busy), 32'(0));
        check("clr_done", 32'(done), 32'(0));
        check("clr_quotient", quotient, 32'd0);
        check("clr_remainder", remainder, 32'd0);
        #2;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_clr", 32'(busy), 32'(0));
        start_div(0, 32'd50, 32'd5, 32'd10, 32'd0, 0);
        wait_done(34, 0, 0);
        @(posedge clk);
        #1;

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
